// File: rtl/motor_pkg.sv
// Shared types and constants for the motor ramp controller: FSM states,
// NEC key codes and frame field offsets.
package motor_pkg;

  localparam int RATE_W_DEF = 7;

  localparam logic [7:0] NEC_ADDR_DEF = 8'h00;
  localparam logic [7:0] KEY_PWR_DEF  = 8'h45;
  localparam logic [7:0] KEY_UP_DEF   = 8'h46;
  localparam logic [7:0] KEY_DN_DEF   = 8'h47;

  // Byte offsets inside a 32-bit NEC frame.
  localparam int FRM_ADDR_LSB  = 24;
  localparam int FRM_NADDR_LSB = 16;
  localparam int FRM_CMD_LSB   = 8;
  localparam int FRM_NCMD_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_UP   = 2'd1,
    LK_DN   = 2'd2
  } last_key_e;

endpackage

// File: rtl/ramp_tick.sv
// Duty-step prescaler: counts 0..RAMP_DIV-1 and pulses step on the last count.
// A synchronous clear holds the count at zero.
module ramp_tick #(
  parameter int RAMP_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic step
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0] TC = TW'(RAMP_DIV - 1);

  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q + 1'b1;
    if (clr || (tick_q == TC)) begin
      tick_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign step = !clr && (tick_q == TC);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Motor ramp sequencer between the NEC decoder and the PWM generator.
// Define MOTOR_KEY_REPEAT_EN to let NEC repeat codes re-apply the last UP/DN key.
//
// state | meaning
// IDLE  | drive off, duty held at 0, target editable
// RUN   | drive on, duty slews toward target one unit per step
// STOP  | drive on, duty slews down to 0, then drive turns off
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int         RATE_W     = RATE_W_DEF,
  parameter int         RATE_MAX   = 100,
  parameter int         RATE_STEP  = 10,
  parameter int         START_RATE = 30,
  parameter int         RAMP_DIV   = 1000,
  parameter logic [7:0] NEC_ADDR   = NEC_ADDR_DEF,
  parameter logic [7:0] KEY_PWR    = KEY_PWR_DEF,
  parameter logic [7:0] KEY_UP     = KEY_UP_DEF,
  parameter logic [7:0] KEY_DN     = KEY_DN_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_vld,
  input  logic [31:0]       frame,
  input  logic              repeat_vld,
  output logic              SW,
  output logic [RATE_W-1:0] RateSet,
  output logic              busy,
  output logic              key_err
);

  localparam logic [RATE_W-1:0] MAX_V   = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] STEP_V  = RATE_W'(RATE_STEP);
  localparam logic [RATE_W-1:0] START_V = RATE_W'(START_RATE);

  state_e            state_q, state_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] tgt_q, tgt_d;
  logic              key_err_q, key_err_d;
  logic              step;

  logic [7:0] f_addr, f_naddr, f_cmd, f_ncmd;
  logic       is_pwr, is_up, is_dn, frame_ok, frame_bad;
  logic       key_pwr, key_up, key_dn, rep_up, rep_dn;

  assign f_addr  = frame[FRM_ADDR_LSB +: 8];
  assign f_naddr = frame[FRM_NADDR_LSB +: 8];
  assign f_cmd   = frame[FRM_CMD_LSB +: 8];
  assign f_ncmd  = frame[FRM_NCMD_LSB +: 8];

  assign is_pwr = (f_cmd == KEY_PWR);
  assign is_up  = (f_cmd == KEY_UP);
  assign is_dn  = (f_cmd == KEY_DN);

  assign frame_ok  = frame_vld && (f_addr == NEC_ADDR) &&
                     ((f_addr ^ f_naddr) == 8'hFF) &&
                     ((f_cmd ^ f_ncmd) == 8'hFF) &&
                     (is_pwr || is_up || is_dn);
  assign frame_bad = frame_vld && !frame_ok;

`ifdef MOTOR_KEY_REPEAT_EN
  last_key_e last_key_q, last_key_d;

  always_comb begin
    last_key_d = last_key_q;
    if (frame_bad || (frame_ok && is_pwr)) begin
      last_key_d = LK_NONE;
    end else if (frame_ok && is_up) begin
      last_key_d = LK_UP;
    end else if (frame_ok && is_dn) begin
      last_key_d = LK_DN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_key_q <= LK_NONE;
    end else begin
      last_key_q <= last_key_d;
    end
  end

  // A fresh frame in the same cycle takes precedence over a repeat code.
  assign rep_up = repeat_vld && !frame_vld && (last_key_q == LK_UP);
  assign rep_dn = repeat_vld && !frame_vld && (last_key_q == LK_DN);
`else
  logic unused_repeat;
  assign unused_repeat = repeat_vld;
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign key_pwr = frame_ok && is_pwr;
  assign key_up  = (frame_ok && is_up) || rep_up;
  assign key_dn  = (frame_ok && is_dn) || rep_dn;

  ramp_tick #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp_tick (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (state_q == ST_IDLE),
    .step  (step)
  );

  // One extra bit so the sum cannot wrap before saturation.
  logic [RATE_W:0]   tgt_sum;
  logic [RATE_W-1:0] tgt_up, tgt_dn;

  assign tgt_sum = {1'b0, tgt_q} + {1'b0, STEP_V};
  assign tgt_up  = (tgt_sum > {1'b0, MAX_V}) ? MAX_V : tgt_sum[RATE_W-1:0];
  assign tgt_dn  = (tgt_q > STEP_V) ? (tgt_q - STEP_V) : '0;

  always_comb begin
    tgt_d     = tgt_q;
    key_err_d = frame_bad;
    if (key_up) begin
      tgt_d = tgt_up;
    end else if (key_dn) begin
      tgt_d = tgt_dn;
    end
  end

  // Steps compare against the registered target, so a key landing on a step
  // cycle only affects the following steps.
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    case (state_q)
      ST_IDLE: begin
        rate_d = '0;
        if (key_pwr) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          if (rate_q < tgt_q) begin
            rate_d = rate_q + 1'b1;
          end else if (rate_q > tgt_q) begin
            rate_d = rate_q - 1'b1;
          end
        end
        if (key_pwr) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (step && (rate_q != '0)) begin
          rate_d = rate_q - 1'b1;
        end
        if (key_pwr) begin
          state_d = ST_RUN;
        end else if (rate_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rate_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      rate_q    <= '0;
      tgt_q     <= START_V;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      tgt_q     <= tgt_d;
      key_err_q <= key_err_d;
    end
  end

  assign SW      = (state_q != ST_IDLE);
  assign RateSet = rate_q;
  assign busy    = (state_q == ST_STOP) || ((state_q == ST_RUN) && (rate_q != tgt_q));
  assign key_err = key_err_q;

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Sequencing controller between the NEC decoder and the PWM generator.
- Accepts validated 32-bit NEC frames (power, speed-up and speed-down keys) and holds a target duty.
- Slews the PWM duty (RateSet) toward the target at a fixed ramp rate; soft-starts and soft-stops the motor.
- Gates the drive-enable (SW) so the motor is never switched on or off at non-zero duty.

Parameters:
- RATE_W, 7: width of target/RateSet.
- RATE_MAX, 100: upper duty saturation value.
- RATE_STEP, 10: target change per up/down key.
- START_RATE, 30: target after reset.
- RAMP_DIV, 1000: CLK cycles per 1-unit duty step.
- NEC_ADDR, 8'h00: accepted remote address.
- KEY_PWR, 8'h45: power-toggle command code.
- KEY_UP, 8'h46: speed-up command code.
- KEY_DN, 8'h47: speed-down command code.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- frame_vld  in  1  one-cycle strobe, frame valid.
- frame  in  32  [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- repeat_vld  in  1  one-cycle NEC repeat-code strobe.
- SW  out  1  motor drive enable.
- RateSet  out  RATE_W  current PWM duty.
- busy  out  1  ramp in progress.
- key_err  out  1  one-cycle pulse, rejected frame.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, SW=0, RateSet=0, tgt=START_RATE, tick=0, busy=0, key_err=0, last_key=none.
- Frame acceptance:
  - Accepted only when frame_vld=1, addr==NEC_ADDR, addr^~addr==8'hFF and cmd^~cmd==8'hFF, and cmd is one of the three keys.
  - Otherwise key_err=1 on the next cycle and no other state change.
- Latency: all key effects (state, tgt, SW) are registered and appear one cycle after frame_vld.
- Tick prescaler: 0..RAMP_DIV-1 counter. Held at 0 in IDLE, free-running in RUN and STOP. A step fires when tick==RAMP_DIV-1.
- State IDLE (SW=0, RateSet=0):
  - PWR -> RUN, SW=1, RateSet stays 0.
  - UP: tgt=min(tgt+RATE_STEP, RATE_MAX).
  - DN: tgt=(tgt>RATE_STEP)?tgt-RATE_STEP:0.
- State RUN (SW=1):
  - On each step, RateSet moves 1 toward tgt; holds when equal.
  - UP/DN modify tgt as in IDLE.
  - PWR -> STOP.
  - busy=(RateSet!=tgt).
- State STOP (SW=1, busy=1):
  - On each step, RateSet decrements by 1.
  - When a step leaves RateSet==0, or on entry with RateSet==0, go to IDLE next cycle with SW=0.
  - PWR -> RUN (resume ramp to tgt).
  - UP/DN: tgt updated, ramp-down continues.
- tgt is preserved across stop/start cycles.
- Simultaneous key and step in one cycle: the step compares against the pre-update tgt; the new tgt governs subsequent steps. A 1-unit transient overshoot is allowed.
- tgt=0 in RUN: RateSet ramps to 0 and SW stays 1.
- Arithmetic: tgt+RATE_STEP is computed at RATE_W+1 bits before saturation. No wrap-around anywhere.

Optional Feature:
- Macro MOTOR_KEY_REPEAT_EN.
- Defined:
  - repeat_vld re-applies last_key if it was UP or DN, with identical saturation.
  - last_key is cleared by PWR, reset, or any rejected frame.
- Undefined: repeat_vld is ignored; last_key logic is not synthesized.

Decomposition:
- Package motor_pkg holds:
  - state enum (IDLE, RUN, STOP);
  - key-code constants;
  - NEC frame field offsets;
  - RATE_W default.
- One sub-module, ramp_tick: the RAMP_DIV prescaler with a synchronous clear and a step pulse output.

Test Plan:
All scenarios use RAMP_DIV=4.
- Reset, then PWR frame {00,FF,45,BA}: SW=1 next cycle; RateSet reaches 30 after 120 cycles; busy falls then.
- UP x8 in RUN: tgt saturates at 100 and RateSet ramps to 100; then DN x11: tgt=0, RateSet ramps to 0, SW stays 1.
- PWR in RUN at RateSet=30:
  - RateSet counts down to 0 in 120 cycles, then SW=0, state IDLE.
  - A second PWR mid-ramp at RateSet=12 resumes the climb to 30.
- Bad frames {00,FF,45,BB}, {01,FE,45,BA} and unknown cmd 8'h10: key_err pulses for one cycle each; SW, RateSet and tgt are unchanged.
- RST asserted mid-ramp at RateSet=17: SW=0, RateSet=0 and busy=0 immediately without waiting for a clock edge; tgt=30.
- With MOTOR_KEY_REPEAT_EN: UP then 3 repeat_vld gives tgt=70; PWR then repeat_vld leaves tgt unchanged. Without the macro, repeat_vld leaves tgt at 40.
